// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction fetch stage with IF/ID pipeline register
//
// Owns the PC, fetches one word at a time over a req/gnt/rvalid handshake
// (never more than one request outstanding), and presents the fetched
// instruction to decode through the IF/ID register. Handles stalls, flushes,
// redirects, and discards wrong-path responses that are still in flight.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   stall                  hold the IF/ID register
//   flush                  replace the IF/ID contents with a bubble
//   redirect, redirect_pc  branch/jump taken; target bits [1:0] are ignored
//   imem_req, imem_addr    fetch request and its address (the PC)
//   imem_gnt               memory accepted the request this cycle
//   imem_rvalid, imem_rdata  response valid and instruction word
//   id_valid, id_pc, id_inst  IF/ID register contents
//   id_pc_plus4            id_pc + 4, combinational, wraps at 2^32

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc_plus4
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;

    logic [31:0] redirect_tgt;
    logic        accept;
    logic        unused_rpc_lsbs;

    assign redirect_tgt    = {redirect_pc[31:2], 2'b00};
    assign unused_rpc_lsbs = ^redirect_pc[1:0];

    // Only a response to a right-path request, arriving while we are still
    // waiting for it and not being overtaken by a redirect, is kept.
    assign accept = (state_q == S_WAIT) && imem_rvalid && !redirect;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        buf_valid_d = buf_valid_q;
        buf_inst_d  = buf_inst_q;
        buf_pc_d    = buf_pc_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    // A granted request is now wrong-path: drain its response.
                    state_d = imem_gnt ? S_DRAIN : S_REQ;
                end else if (imem_gnt) begin
                    pc_d     = pc_q + 32'd4;
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    if (stall || flush) begin
                        // IF/ID cannot take it this cycle; park it.
                        buf_valid_d = 1'b1;
                        buf_inst_d  = imem_rdata;
                        buf_pc_d    = req_pc_q;
                        state_d     = S_HOLD;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    buf_valid_d = 1'b0;
                    state_d     = S_REQ;
                end else if (!stall && !flush) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect) begin
            pc_d = redirect_tgt;
        end

        if (flush) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end else if (stall) begin
            id_valid_d = id_valid_q;
        end else if (buf_valid_q && !redirect) begin
            id_valid_d  = 1'b1;
            id_inst_d   = buf_inst_q;
            id_pc_d     = buf_pc_q;
            buf_valid_d = 1'b0;
        end else if (accept) begin
            id_valid_d = 1'b1;
            id_inst_d  = imem_rdata;
            id_pc_d    = req_pc_q;
        end else begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= 32'd0;
            buf_valid_q <= 1'b0;
            buf_inst_q  <= NOP_INST;
            buf_pc_q    <= 32'd0;
            id_valid_q  <= 1'b0;
            id_pc_q     <= 32'd0;
            id_inst_q   <= NOP_INST;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_inst_q  <= buf_inst_d;
            buf_pc_q    <= buf_pc_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_inst     = id_inst_q;
    assign id_pc_plus4 = id_pc_q + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        id_valid;
    logic [31:0] id_pc, id_inst, id_pc_plus4;

    int checks = 0;
    int failures = 0;

    if_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .id_pc_plus4(id_pc_plus4)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_inst);
        chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
        chk({tag, ".imem_addr"}, imem_addr, e_addr);
        chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, e_valid});
        chk({tag, ".id_pc"}, id_pc, e_pc);
        chk({tag, ".id_inst"}, id_inst, e_inst);
        chk({tag, ".id_pc_plus4"}, id_pc_plus4, e_pc + 32'd4);
    endtask

    typedef struct {
        logic        st, fl, rd;
        logic [31:0] rpc;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                                input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_pc, input logic [31:0] e_inst);
        vec_t v;
        v.st = st; v.fl = fl; v.rd = rd; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    // Reference model state: abstract fetch bookkeeping, not an FSM encoding.
    logic        m_started, m_out, m_stale, m_buf_v, m_idv;
    logic [31:0] m_pc, m_req_pc, m_buf_inst, m_buf_pc, m_id_pc, m_id_inst;

    task automatic model_reset();
        m_started = 0; m_out = 0; m_stale = 0; m_buf_v = 0; m_idv = 0;
        m_pc = RST_PC; m_req_pc = 0; m_buf_inst = NOP; m_buf_pc = 0;
        m_id_pc = 0; m_id_inst = NOP;
    endtask

    function automatic logic model_req();
        return m_started && !m_out && !m_buf_v;
    endfunction

    task automatic model_step(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                              input logic gnt, input logic rv, input logic [31:0] rdata);
        logic req, acc;
        req = model_req();
        acc = m_out && !m_stale && rv && !rd;
        if (fl) begin
            m_idv = 0; m_id_inst = NOP;
        end else if (st) begin
        end else if (m_buf_v && !rd) begin
            m_idv = 1; m_id_inst = m_buf_inst; m_id_pc = m_buf_pc;
        end else if (acc) begin
            m_idv = 1; m_id_inst = rdata; m_id_pc = m_req_pc;
        end else begin
            m_idv = 0; m_id_inst = NOP;
        end
        if (acc && (st || fl)) begin
            m_buf_v = 1; m_buf_inst = rdata; m_buf_pc = m_req_pc;
        end else if (m_buf_v && (rd || (!st && !fl))) begin
            m_buf_v = 0;
        end
        if (m_out && rv) m_out = 0;
        else if (m_out && rd) m_stale = 1;
        if (req && gnt) begin
            m_out = 1; m_stale = rd;
            if (!rd) m_req_pc = m_pc;
        end
        if (rd) m_pc = rpc & 32'hFFFF_FFFC;
        else if (req && gnt) m_pc = m_pc + 32'd4;
        m_started = 1;
    endtask

    vec_t vecs[25];

    initial begin
        vecs[0]  = mk(0,0,0,0,            0,0,0,            0,32'h100,     0,32'h0,       NOP);
        vecs[1]  = mk(0,0,0,0,            1,0,0,            1,32'h100,     0,32'h0,       NOP);
        vecs[2]  = mk(0,0,0,0,            0,1,32'h00A00093, 0,32'h104,     0,32'h0,       NOP);
        vecs[3]  = mk(0,0,0,0,            1,0,0,            1,32'h104,     1,32'h100,     32'h00A00093);
        vecs[4]  = mk(0,0,0,0,            0,1,32'h00208133, 0,32'h108,     0,32'h100,     NOP);
        vecs[5]  = mk(0,0,0,0,            1,0,0,            1,32'h108,     1,32'h104,     32'h00208133);
        vecs[6]  = mk(1,0,0,0,            0,1,32'h40310233, 0,32'h10C,     0,32'h104,     NOP);
        vecs[7]  = mk(1,0,0,0,            0,0,0,            0,32'h10C,     0,32'h104,     NOP);
        vecs[8]  = mk(1,0,0,0,            0,0,0,            0,32'h10C,     0,32'h104,     NOP);
        vecs[9]  = mk(0,0,0,0,            0,0,0,            0,32'h10C,     0,32'h104,     NOP);
        vecs[10] = mk(0,0,0,0,            0,0,0,            1,32'h10C,     1,32'h108,     32'h40310233);
        vecs[11] = mk(0,0,0,0,            1,0,0,            1,32'h10C,     0,32'h108,     NOP);
        vecs[12] = mk(0,0,1,32'h2003,     0,0,0,            0,32'h110,     0,32'h108,     NOP);
        vecs[13] = mk(0,0,0,0,            0,0,0,            0,32'h2000,    0,32'h108,     NOP);
        vecs[14] = mk(0,0,0,0,            0,0,0,            0,32'h2000,    0,32'h108,     NOP);
        vecs[15] = mk(0,0,0,0,            0,1,32'hDEADBEEF, 0,32'h2000,    0,32'h108,     NOP);
        vecs[16] = mk(0,0,1,32'h400,      1,0,0,            1,32'h2000,    0,32'h108,     NOP);
        vecs[17] = mk(0,0,0,0,            0,1,32'h0BADF00D, 0,32'h400,     0,32'h108,     NOP);
        vecs[18] = mk(0,0,0,0,            1,0,0,            1,32'h400,     0,32'h108,     NOP);
        vecs[19] = mk(1,1,0,0,            0,1,32'h00C00513, 0,32'h404,     0,32'h108,     NOP);
        vecs[20] = mk(1,0,1,32'hFFFFFFFC, 0,0,0,            0,32'h404,     0,32'h108,     NOP);
        vecs[21] = mk(0,0,0,0,            1,0,0,            1,32'hFFFFFFFC,0,32'h108,     NOP);
        vecs[22] = mk(0,0,0,0,            0,1,32'h00100073, 0,32'h0,       0,32'h108,     NOP);
        vecs[23] = mk(0,0,0,0,            1,0,0,            1,32'h0,       1,32'hFFFFFFFC,32'h00100073);
        vecs[24] = mk(0,0,0,0,            0,0,0,            0,32'h4,       0,32'hFFFFFFFC,NOP);

        // Directed table from reset.
        repeat (2) @(negedge clk);
        reset = 0;
        for (int i = 0; i < 25; i++) begin
            if (i > 0) @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                    vecs[i].e_pc, vecs[i].e_inst);
            stall = vecs[i].st; flush = vecs[i].fl; redirect = vecs[i].rd;
            redirect_pc = vecs[i].rpc; imem_gnt = vecs[i].gnt;
            imem_rvalid = vecs[i].rv; imem_rdata = vecs[i].rdata;
        end

        // Asynchronous reset in the middle of an outstanding fetch.
        @(negedge clk);
        stall = 0; flush = 0; redirect = 0; imem_gnt = 0; imem_rvalid = 0;
        chk_all("pre_reset", 1'b0, 32'h4, 1'b0, 32'hFFFFFFFC, NOP);
        #2 reset = 1;
        #1 chk_all("async_reset", 1'b0, RST_PC, 1'b0, 32'h0, NOP);
        @(negedge clk);
        reset = 0;
        chk_all("reset_idle", 1'b0, RST_PC, 1'b0, 32'h0, NOP);
        @(negedge clk);
        chk_all("first_req", 1'b1, RST_PC, 1'b0, 32'h0, NOP);

        // Randomized run against the reference model.
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            logic st, fl, rd, g, rv;
            logic [31:0] rpc, rdat;
            if (n > 0) @(negedge clk);
            chk_all($sformatf("rnd%0d", n), model_req(), m_pc, m_idv, m_id_pc, m_id_inst);
            st   = ($urandom_range(0, 4) == 0);
            fl   = ($urandom_range(0, 9) == 0);
            rd   = ($urandom_range(0, 9) == 0);
            rpc  = $urandom;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFFC | ($urandom & 32'h3);
            g    = $urandom_range(0, 1);
            rv   = m_out && ($urandom_range(0, 2) == 0);
            rdat = $urandom;
            stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
            imem_gnt = g; imem_rvalid = rv; imem_rdata = rdat;
            model_step(st, fl, rd, rpc, g, rv, rdat);
        end

        @(negedge clk);
        stall = 0; flush = 0; redirect = 0; imem_gnt = 0; imem_rvalid = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
